// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and constants for the OAM DMA bus arbiter.
// Imported by the DMA engine and the arbiter top.
package oam_dma_arbiter_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_ARM,
        DMA_XFER
    } dma_state_t;

    typedef enum logic [1:0] {
        RD_HRAM,
        RD_DREG,
        RD_MAIN,
        RD_BLOCKED
    } rd_src_t;

    localparam logic [15:0] OAM_BASE = 16'hFE00;
    localparam logic [15:0] HRAM_LO  = 16'hFF80;
    localparam logic [15:0] HRAM_HI  = 16'hFFFE;

    // Echo RAM sources fold back onto work RAM.
    function automatic logic [7:0] src_effective(
        input logic [7:0] src,
        input logic       mirror
    );
        return (mirror && src >= 8'hE0) ? src - 8'h20 : src;
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA sequencer: arm delay, per-byte slot counter and main bus drive.
// Bus drive outputs are only meaningful while the state is DMA_XFER.
module oam_dma_engine
    import oam_dma_arbiter_pkg::*;
#(
    parameter int SLOT_CYCLES = 4,
    parameter int DMA_LEN     = 160,
    parameter bit MIRROR_ECHO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dreg_wr,
    input  logic [7:0]  dreg_wdata,
    input  logic [7:0]  mem_rdata,
    output dma_state_t  state,
    output logic [7:0]  dma_src,
    output logic [15:0] bus_addr,
    output logic        bus_we,
    output logic [7:0]  bus_wdata,
    output logic        busy,
    output logic        done
);

    localparam int PW = $clog2(SLOT_CYCLES);
    localparam logic [PW-1:0] LAST_PHASE = PW'(SLOT_CYCLES - 1);
    localparam logic [7:0]    LAST_IDX   = 8'(DMA_LEN - 1);

    logic [7:0]    idx;
    logic [PW-1:0] phase;
    logic [7:0]    src_eff;

    assign src_eff = src_effective(dma_src, MIRROR_ECHO);
    assign busy    = (state != DMA_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DMA_IDLE;
            dma_src <= 8'h00;
            idx     <= 8'h00;
            phase   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            // A source write always wins and restarts from the arm delay.
            if (dreg_wr) begin
                dma_src <= dreg_wdata;
                state   <= DMA_ARM;
                idx     <= 8'h00;
                phase   <= '0;
            end else begin
                unique case (state)
                    DMA_ARM: begin
                        if (phase == LAST_PHASE) begin
                            state <= DMA_XFER;
                            phase <= '0;
                            idx   <= 8'h00;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                    DMA_XFER: begin
                        if (phase == LAST_PHASE) begin
                            phase <= '0;
                            if (idx == LAST_IDX) begin
                                state <= DMA_IDLE;
                                idx   <= 8'h00;
                                done  <= 1'b1;
                            end else begin
                                idx <= idx + 8'h01;
                            end
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                    default: begin
                        phase <= '0;
                    end
                endcase
            end
        end
    end

    // Phase 0 reads the source byte, phase 1 writes it into OAM.
    always_comb begin
        bus_addr  = 16'h0000;
        bus_we    = 1'b0;
        bus_wdata = 8'h00;
        if (state == DMA_XFER) begin
            if (phase == PW'(0)) begin
                bus_addr = {src_eff, idx};
            end else if (phase == PW'(1)) begin
                bus_addr  = OAM_BASE + {8'h00, idx};
                bus_we    = !dreg_wr;
                bus_wdata = mem_rdata;
            end
        end
    end

endmodule

// File: rtl/oam_dma_arbiter.sv
// Main bus arbiter between the CPU and the OAM DMA engine.
// HRAM stays reachable on its own port while DMA owns the main bus.
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
#(
    parameter int          SLOT_CYCLES  = 4,
    parameter int          DMA_LEN      = 160,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter bit          MIRROR_ECHO  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [6:0]  hram_addr,
    output logic        hram_we,
    output logic [7:0]  hram_wdata,
    input  logic [7:0]  hram_rdata,
    output logic        dma_busy,
    output logic        dma_done
);

    logic        in_hram;
    logic        in_dreg;
    logic        in_main;
    logic        idle;
    logic        dreg_wr;
    dma_state_t  eng_state;
    logic [7:0]  dma_src;
    logic [15:0] eng_addr;
    logic        eng_we;
    logic [7:0]  eng_wdata;
    rd_src_t     rd_sel;
    rd_src_t     rd_next;

    assign in_hram = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
    assign in_dreg = (cpu_addr == DMA_REG_ADDR);
    assign in_main = !in_hram && !in_dreg;
    assign idle    = (eng_state == DMA_IDLE);
    assign dreg_wr = in_dreg && cpu_we;

    assign hram_addr  = cpu_addr[6:0];
    assign hram_we    = cpu_we && in_hram;
    assign hram_wdata = cpu_wdata;

    oam_dma_engine #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .DMA_LEN     (DMA_LEN),
        .MIRROR_ECHO (MIRROR_ECHO)
    ) u_engine (
        .clk        (clk),
        .rst        (rst),
        .dreg_wr    (dreg_wr),
        .dreg_wdata (cpu_wdata),
        .mem_rdata  (mem_rdata),
        .state      (eng_state),
        .dma_src    (dma_src),
        .bus_addr   (eng_addr),
        .bus_we     (eng_we),
        .bus_wdata  (eng_wdata),
        .busy       (dma_busy),
        .done       (dma_done)
    );

    // Bus held quiet during reset so an interrupted transfer cannot write.
    always_comb begin
        mem_addr  = 16'h0000;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        if (!rst) begin
            if (!idle) begin
                mem_addr  = eng_addr;
                mem_we    = eng_we;
                mem_wdata = eng_wdata;
            end else begin
                mem_addr  = cpu_addr;
                mem_we    = cpu_we && in_main;
                mem_wdata = cpu_wdata;
            end
        end
    end

    always_comb begin
        rd_next = RD_MAIN;
        unique case (1'b1)
            in_hram: rd_next = RD_HRAM;
            in_dreg: rd_next = RD_DREG;
            default: rd_next = idle ? RD_MAIN : RD_BLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sel <= RD_MAIN;
        end else begin
            rd_sel <= rd_next;
        end
    end

    always_comb begin
        cpu_rdata = 8'hFF;
        unique case (rd_sel)
            RD_HRAM: cpu_rdata = hram_rdata;
            RD_DREG: cpu_rdata = dma_src;
            RD_MAIN: cpu_rdata = mem_rdata;
            default: cpu_rdata = 8'hFF;
        endcase
    end

endmodule
